// File: rtl/clz_lanes_pipe.sv
// Multi-lane leading-zero / redundant-sign-bit counter with a two-stage valid/ready pipeline.
// Stage 1 registers per-lane counts; stage 2 adds the minimum count and its lowest lane index.
module clz_lanes_pipe #(
  parameter int width_i   = 8,
  parameter int n_lanes   = 4,
  parameter int width_o   = $clog2(width_i + 1),
  parameter int width_idx = (n_lanes > 1) ? $clog2(n_lanes) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_mode,
  input  logic [n_lanes*width_i-1:0]   i_num,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [n_lanes*width_o-1:0]   o_lz,
  output logic [n_lanes-1:0]           o_zero,
  output logic [width_o-1:0]           o_min_lz,
  output logic [width_idx-1:0]         o_min_idx
);

  // Mode 1 skips the MSB itself and counts the following bits that repeat it.
  function automatic logic [width_o-1:0] lane_count(input logic [width_i-1:0] v, input logic mode);
    logic [width_o-1:0] cnt;
    logic               run;
    logic               ref_bit;
    cnt     = '0;
    run     = 1'b1;
    ref_bit = mode ? v[width_i-1] : 1'b0;
    for (int b = width_i - 1; b >= 0; b--) begin
      if (!(mode && (b == width_i - 1))) begin
        if (run && (v[b] == ref_bit)) cnt = cnt + 1'b1;
        else                          run = 1'b0;
      end
    end
    return cnt;
  endfunction

  logic                        s1_valid;
  logic [n_lanes*width_o-1:0]  s1_lz;
  logic [n_lanes-1:0]          s1_zero;
  logic                        s2_valid;
  logic [n_lanes*width_o-1:0]  s2_lz;
  logic [n_lanes-1:0]          s2_zero;
  logic [width_o-1:0]          s2_min_lz;
  logic [width_idx-1:0]        s2_min_idx;

  logic                        s1_load;
  logic                        s2_load;
  logic [n_lanes*width_o-1:0]  lz_d;
  logic [n_lanes-1:0]          zero_d;
  logic [width_o-1:0]          min_lz_d;
  logic [width_idx-1:0]        min_idx_d;

  // Handshake: a beat moves on an edge where valid && ready; a stage loads when it is
  // empty or the stage after it is loading, so both stages together buffer at most two beats.
  assign s2_load = !s2_valid || i_ready;
  assign s1_load = !s1_valid || s2_load;
  assign o_ready = !i_rst && s1_load;

  always_comb begin
    lz_d   = '0;
    zero_d = '0;
    for (int k = 0; k < n_lanes; k++) begin
      lz_d[k*width_o +: width_o] = lane_count(i_num[k*width_i +: width_i], i_mode);
      zero_d[k] = i_mode ? (i_num[k*width_i +: width_i] == {width_i{i_num[k*width_i + width_i - 1]}})
                         : (i_num[k*width_i +: width_i] == '0);
    end
  end

  // Strict less-than keeps the lowest lane on ties.
  always_comb begin
    min_lz_d  = s1_lz[0 +: width_o];
    min_idx_d = '0;
    for (int k = 1; k < n_lanes; k++) begin
      if (s1_lz[k*width_o +: width_o] < min_lz_d) begin
        min_lz_d  = s1_lz[k*width_o +: width_o];
        min_idx_d = width_idx'(k);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid   <= 1'b0;
      s1_lz      <= '0;
      s1_zero    <= '0;
      s2_valid   <= 1'b0;
      s2_lz      <= '0;
      s2_zero    <= '0;
      s2_min_lz  <= '0;
      s2_min_idx <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= i_valid;
        if (i_valid) begin
          s1_lz   <= lz_d;
          s1_zero <= zero_d;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_lz      <= s1_lz;
          s2_zero    <= s1_zero;
          s2_min_lz  <= min_lz_d;
          s2_min_idx <= min_idx_d;
        end
      end
    end
  end

  assign o_valid   = s2_valid;
  assign o_lz      = s2_lz;
  assign o_zero    = s2_zero;
  assign o_min_lz  = s2_min_lz;
  assign o_min_idx = s2_min_idx;

endmodule

// File: tb/tb_clz_lanes_pipe.sv
// Bench for clz_lanes_pipe: directed vectors, backpressure, reset flush and random streaming
// checked against a bit-length based reference model through an expected-beat queue.
module tb_clz_lanes_pipe;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int WO = $clog2(W + 1);
  localparam int WI = (N > 1) ? $clog2(N) : 1;
  localparam int PW = N*WO + N + WO + WI;

  logic          clk;
  logic          i_rst;
  logic          i_valid;
  logic          o_ready;
  logic          i_mode;
  logic [N*W-1:0]  i_num;
  logic          o_valid;
  logic          i_ready;
  logic [N*WO-1:0] o_lz;
  logic [N-1:0]    o_zero;
  logic [WO-1:0]   o_min_lz;
  logic [WI-1:0]   o_min_idx;

  logic [PW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int accepts = 0;
  int xfers = 0;

  clz_lanes_pipe #(.width_i(W), .n_lanes(N)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
    .i_num(i_num), .o_valid(o_valid), .i_ready(i_ready), .o_lz(o_lz), .o_zero(o_zero),
    .o_min_lz(o_min_lz), .o_min_idx(o_min_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic int bitlen(input logic [W-1:0] v);
    int n = 0;
    while (v != 0) begin
      v = v >> 1;
      n++;
    end
    return n;
  endfunction

  function automatic logic [PW-1:0] model(input logic [N*W-1:0] num, input logic mode);
    int cnt[N];
    logic [N-1:0]    z;
    logic [N*WO-1:0] lz;
    logic [W-1:0]    lv;
    int mn;
    int idx;
    for (int k = 0; k < N; k++) begin
      lv = num[k*W +: W];
      if (mode && lv[W-1]) lv = ~lv;
      cnt[k] = mode ? (W - 1 - bitlen(lv)) : (W - bitlen(lv));
      z[k] = (lv == 0);
      lz[k*WO +: WO] = WO'(cnt[k]);
    end
    mn = W;
    for (int k = 0; k < N; k++) if (cnt[k] < mn) mn = cnt[k];
    idx = 0;
    for (int k = N - 1; k >= 0; k--) if (cnt[k] == mn) idx = k;
    return {lz, z, WO'(mn), WI'(idx)};
  endfunction

  function automatic logic [N*W-1:0] rand_num();
    logic [N*W-1:0] r;
    logic [W-1:0]   v;
    for (int k = 0; k < N; k++) begin
      v = W'($urandom_range(0, 255) >> $urandom_range(0, 8));
      if ($urandom_range(0, 1) == 1) v = ~v;
      r[k*W +: W] = v;
    end
    return r;
  endfunction

  // scoreboard: sampled on the falling edge, between driver updates
  always @(negedge clk) begin
    if (i_rst) begin
      exp_q.delete();
    end else begin
      if (o_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", {63'b0, o_valid}, 64'd0);
        else begin
          chk("beat", {o_lz, o_zero, o_min_lz, o_min_idx}, exp_q[0]);
          if (i_ready) begin
            void'(exp_q.pop_front());
            xfers++;
          end
        end
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_num, i_mode));
        accepts++;
      end
    end
  end

  // driver tasks; each returns at posedge+1
  task automatic send(input logic [N*W-1:0] num, input logic mode);
    bit done;
    done = 1'b0;
    i_valid = 1'b1;
    i_num = num;
    i_mode = mode;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = o_ready;
      @(posedge clk);
      #1;
    end
    chk("send_accept", {63'b0, done}, 64'd1);
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int t = 0; t < 100 && !empty; t++) begin
      @(posedge clk);
      #1;
      empty = (exp_q.size() == 0) && !o_valid;
    end
    chk("drain_empty", {63'b0, empty}, 64'd1);
  endtask

  initial begin
    int x0;
    int a0;
    logic mode_t;
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_num = '0;
    i_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", {63'b0, o_valid}, 64'd0);
    chk("rst_ready", {63'b0, o_ready}, 64'd0);
    chk("rst_outs", {o_lz, o_zero, o_min_lz, o_min_idx}, 64'd0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {63'b0, o_ready}, 64'd1);
    @(posedge clk);
    #1;

    // vector 1: mode 0, also checks two-cycle latency
    send({8'h10, 8'h00, 8'h01, 8'h80}, 1'b0);
    i_valid = 1'b0;
    @(negedge clk);
    chk("v1_not_yet", {63'b0, o_valid}, 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("v1_valid", {63'b0, o_valid}, 64'd1);
    chk("v1_lz", o_lz, 64'h3870);
    chk("v1_zero", o_zero, 64'b0100);
    chk("v1_min", {o_min_lz, o_min_idx}, {WO'(0), WI'(0)});
    drain();

    // vector 2: mode 1
    send({8'h40, 8'h3F, 8'hC0, 8'hFF}, 1'b1);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("v2_lz", o_lz, 64'h0117);
    chk("v2_zero", o_zero, 64'b0001);
    chk("v2_min", {o_min_lz, o_min_idx}, {WO'(0), WI'(3)});
    drain();

    // vector 3: tie resolves to lowest lane
    send({8'h01, 8'h0C, 8'h08, 8'h0F}, 1'b0);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("v3_lz", o_lz, 64'h7444);
    chk("v3_min", {o_min_lz, o_min_idx}, {WO'(4), WI'(0)});
    drain();

    // backpressure: six beats with the sink stalled
    x0 = xfers;
    i_ready = 1'b0;
    send(rand_num(), 1'b0);
    send(rand_num(), 1'b1);
    i_num = rand_num();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_ready_low", {63'b0, o_ready}, 64'd0);
      chk("bp_valid_held", {63'b0, o_valid}, 64'd1);
      @(posedge clk);
      #1;
    end
    i_ready = 1'b1;
    for (int b = 2; b < 6; b++) send(rand_num(), b[0]);
    drain();
    chk("bp_count", 64'(xfers - x0), 64'd6);

    // full throughput with both sides held high
    for (int c = 0; c < 30; c++) begin
      i_valid = 1'b1;
      i_num = rand_num();
      i_mode = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("tp_ready", {63'b0, o_ready}, 64'd1);
      if (c >= 2) chk("tp_valid", {63'b0, o_valid}, 64'd1);
      @(posedge clk);
      #1;
    end
    drain();

    // random bubbles on both sides, alternating mode
    a0 = accepts;
    mode_t = 1'b0;
    for (int c = 0; c < 3000 && (accepts - a0) < 200; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      i_num = rand_num();
      i_mode = mode_t;
      mode_t = ~mode_t;
      @(posedge clk);
      #1;
    end
    chk("rand_accepts", 64'(accepts - a0), 64'd200);
    drain();

    // reset with two beats in flight
    i_ready = 1'b0;
    send(rand_num(), 1'b0);
    send(rand_num(), 1'b1);
    i_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {63'b0, o_ready}, 64'd0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {63'b0, o_valid}, 64'd0);
    chk("midrst_outs", {o_lz, o_zero, o_min_lz, o_min_idx}, 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("midrst_no_stale", {63'b0, o_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    x0 = xfers;
    send({8'hFF, 8'h00, 8'h7F, 8'h20}, 1'b1);
    drain();
    chk("post_rst_beat", 64'(xfers - x0), 64'd1);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
